// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage of the RISC-V pipeline.
// Turns the EX/ME memory controls into a request/grant/rvalid data-memory
// transaction, builds byte strobes and lane-replicated store data, extracts
// and extends load data, and stalls the upstream registers while busy.
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   defined   : misaligned half/word accesses are not issued; they complete
//               in DONE with misalign_out=1.
//   undefined : misalign_out is tied low; low address bits only steer lanes.
//
// Ports:
//   clk, rst (sync, active-low)
//   addr_in, write_data_in, mem_read_in, mem_write_en_in,
//   mem_length_in, mem_sign_in                      - EX/ME controls
//   dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
//   dmem_gnt, dmem_rvalid, dmem_rdata               - data-memory port
//   stall, load_data_out, mem_done, misalign_out    - pipeline side
module mem_access_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       write_data_in,
  input  logic              mem_read_in,
  input  logic              mem_write_en_in,
  input  logic [1:0]        mem_length_in,
  input  logic              mem_sign_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_wstrb,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              stall,
  output logic [31:0]       load_data_out,
  output logic              mem_done,
  output logic              misalign_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic        access;
  logic        misaligned;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  // Store wins when both enables are high, so dmem_we is just the store enable.
  assign access = mem_read_in | mem_write_en_in;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = access &
                      (((mem_length_in == 2'b01) & addr_in[0]) |
                       (mem_length_in[1] & (addr_in[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // Handshake outputs are combinational on state and inputs.
  always_comb begin
    dmem_req = 1'b0;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        dmem_req = access & ~misaligned;
        stall    = access;
      end
      REQ: begin
        dmem_req = 1'b1;
        stall    = 1'b1;
      end
      WAIT:    stall = 1'b1;
      default: ;
    endcase
  end

  assign dmem_we   = mem_write_en_in;
  assign dmem_addr = {addr_in[ADDR_W-1:2], 2'b00};

  // Byte-lane strobes and replicated store data.
  always_comb begin
    dmem_wstrb = 4'b0000;
    dmem_wdata = write_data_in;
    case (mem_length_in)
      2'b00: begin
        dmem_wstrb = 4'b0001 << addr_in[1:0];
        dmem_wdata = {4{write_data_in[7:0]}};
      end
      2'b01: begin
        dmem_wstrb = addr_in[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{write_data_in[15:0]}};
      end
      default: dmem_wstrb = 4'b1111;
    endcase
    if (!mem_write_en_in) dmem_wstrb = 4'b0000;
  end

  // Load extraction: shift the addressed byte to lane 0, then extend.
  always_comb begin
    shifted  = dmem_rdata >> {addr_in[1:0], 3'b000};
    load_ext = shifted;
    case (mem_length_in)
      2'b00: load_ext = mem_sign_in ? {{24{shifted[7]}}, shifted[7:0]}
                                    : {24'h000000, shifted[7:0]};
      2'b01: load_ext = mem_sign_in ? {{16{shifted[15]}}, shifted[15:0]}
                                    : {16'h0000, shifted[15:0]};
      default: ;
    endcase
  end

  // Access FSM with registered completion outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      load_data_out <= 32'h0;
      mem_done      <= 1'b0;
      misalign_out  <= 1'b0;
    end else begin
      mem_done     <= 1'b0;
      misalign_out <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (misaligned) begin
              state        <= DONE;
              mem_done     <= 1'b1;
              misalign_out <= 1'b1;
            end else if (dmem_gnt) begin
              state    <= mem_write_en_in ? DONE : WAIT;
              mem_done <= mem_write_en_in;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            state    <= mem_write_en_in ? DONE : WAIT;
            mem_done <= mem_write_en_in;
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            load_data_out <= load_ext;
            state         <= DONE;
            mem_done      <= 1'b1;
          end
        end
        default: state <= IDLE;  // DONE: EX/ME advances this edge, never re-issue
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed table of accesses, hand-written reset
// and misalignment sequences, then random accesses against a reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wd, rdata;
  logic        rd, wr, sg, gnt, rvalid;
  logic [1:0]  len;
  logic        dmem_req, dmem_we, stall, mem_done, misalign_out;
  logic [31:0] dmem_addr, dmem_wdata, load_data_out;
  logic [3:0]  dmem_wstrb;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_load = 32'h0;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .addr_in(addr), .write_data_in(wd),
    .mem_read_in(rd), .mem_write_en_in(wr), .mem_length_in(len),
    .mem_sign_in(sg), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(gnt), .dmem_rvalid(rvalid), .dmem_rdata(rdata),
    .stall(stall), .load_data_out(load_data_out), .mem_done(mem_done),
    .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        ld;
    logic [31:0] a;
    logic [31:0] w;
    logic [1:0]  ln;
    logic        sgn;
    logic [31:0] rdat;
    int          gd;         // cycles before gnt
    int          rd_dly;     // WAIT cycles before rvalid
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;   // loads only
    int          exp_stall;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, from the access rules with plain arithmetic.
  function automatic logic [31:0] m_load(input logic [31:0] r, input int off,
                                         input logic [1:0] ln, input logic s);
    longint v;
    int nb;
    nb = (ln == 2'd0) ? 8 : (ln == 2'd1) ? 16 : 32;
    v  = longint'(r) / (longint'(1) << (8 * off));
    v  = v % (longint'(1) << nb);
    if (s && nb < 32 && v >= (longint'(1) << (nb - 1))) v = v - (longint'(1) << nb);
    return 32'(v);
  endfunction

  function automatic logic [3:0] m_strb(input int off, input logic [1:0] ln);
    if (ln == 2'd0) return 4'(1 << off);
    if (ln == 2'd1) return (off >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] w, input logic [1:0] ln);
    if (ln == 2'd0) return (w % 256) * 32'h01010101;
    if (ln == 2'd1) return (w % 65536) * 32'h00010001;
    return w;
  endfunction

  function automatic bit m_mis(input vec_t v);
`ifdef MEM_MISALIGN_CHECK_EN
    if (!(v.st || v.ld)) return 1'b0;
    if (v.ln == 2'd1) return v.a[0];
    if (v.ln[1]) return v.a[1:0] != 2'b00;
`endif
    return 1'b0;
  endfunction

  // One full access starting in an IDLE cycle and ending after DONE.
  task automatic run_access(input vec_t v);
    int  stalls;
    bit  mis;
    bit  is_load;
    mis     = m_mis(v);
    is_load = v.ld && !v.st;
    stalls  = 0;
    @(negedge clk);
    rd = v.ld; wr = v.st; addr = v.a; wd = v.w; len = v.ln; sg = v.sgn;
    rdata = $urandom;
    rvalid = 1'($urandom_range(0, 1));  // must be ignored outside WAIT
    gnt = (v.gd == 0) && !mis;
    #1;
    check("we", 32'(dmem_we), 32'(v.st));
    check("addr", dmem_addr, {v.a[31:2], 2'b00});
    check("wstrb", 32'(dmem_wstrb), v.st ? 32'(v.exp_strb) : 32'h0);
    if (v.st) check("wdata", dmem_wdata, v.exp_wdata);
    if (mis) begin
      check("mis_flags", {29'h0, dmem_req, stall, mem_done}, 32'b010);
      stalls++;
      @(posedge clk);
    end else begin
      for (int k = 0; k <= v.gd; k++) begin
        if (k > 0) begin
          @(negedge clk);
          gnt = (k == v.gd);
          rvalid = 1'($urandom_range(0, 1));
          rdata = $urandom;
          #1;
        end
        check("req_flags", {29'h0, dmem_req, stall, mem_done}, 32'b110);
        stalls++;
        @(posedge clk);
      end
      if (is_load) begin
        for (int j = 0; j <= v.rd_dly; j++) begin
          @(negedge clk);
          gnt = 1'b0;
          rvalid = (j == v.rd_dly);
          rdata = (j == v.rd_dly) ? v.rdat : $urandom;
          #1;
          check("wait_flags", {29'h0, dmem_req, stall, mem_done}, 32'b010);
          stalls++;
          @(posedge clk);
        end
      end
    end
    @(negedge clk);
    gnt = 1'b0; rvalid = 1'b0;
    #1;
    check("done_flags", {29'h0, dmem_req, stall, mem_done}, 32'b001);
    check("misalign", 32'(misalign_out), 32'(mis));
    if (is_load && !mis) last_load = v.exp_load;
    check("load_data", load_data_out, last_load);
    check("stall_cycles", 32'(stalls), 32'(v.exp_stall));
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; gnt = 1'b0; rvalid = 1'($urandom_range(0, 1));
    #1;
    check("idle_flags", {29'h0, dmem_req, stall, mem_done}, 32'b000);
    @(posedge clk);
  endtask

  vec_t tbl[8];
  vec_t v;

  initial begin
    rst = 1'b0; addr = 0; wd = 0; rdata = 0; rd = 0; wr = 0; sg = 0;
    gnt = 0; rvalid = 0; len = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_flags", {28'h0, dmem_req, stall, mem_done, misalign_out}, 32'h0);
    check("rst_load", load_data_out, 32'h0);
    rst = 1'b1;
    @(posedge clk);

    //            st ld addr      wd           ln    sg rdata        gd rd strb     wdata        load         stall
    tbl[0] = '{1, 0, 32'h100, 32'hDEADBEEF, 2'd2, 0, 32'h0,        0, 0, 4'b1111, 32'hDEADBEEF, 32'h0,        1};
    tbl[1] = '{0, 1, 32'h203, 32'h0,        2'd0, 1, 32'h80123456, 2, 0, 4'b0000, 32'h0,        32'hFFFFFF80, 4};
    tbl[2] = '{0, 1, 32'h202, 32'h0,        2'd1, 0, 32'h80011234, 0, 0, 4'b0000, 32'h0,        32'h00008001, 2};
    tbl[3] = '{0, 1, 32'h202, 32'h0,        2'd1, 1, 32'h80011234, 0, 0, 4'b0000, 32'h0,        32'hFFFF8001, 2};
    tbl[4] = '{1, 0, 32'h011, 32'h000000AB, 2'd0, 0, 32'h0,        0, 0, 4'b0010, 32'hABABABAB, 32'h0,        1};
    tbl[5] = '{1, 0, 32'h012, 32'h1234CAFE, 2'd1, 0, 32'h0,        1, 0, 4'b1100, 32'hCAFECAFE, 32'h0,        2};
    tbl[6] = '{0, 1, 32'h300, 32'h0,        2'd3, 0, 32'h12345678, 1, 2, 4'b0000, 32'h0,        32'h12345678, 5};
    tbl[7] = '{1, 1, 32'h304, 32'h00000000, 2'd2, 0, 32'hFFFFFFFF, 0, 0, 4'b1111, 32'h0,        32'h0,        1};
    foreach (tbl[i]) run_access(tbl[i]);   // back-to-back, no idle gap
    idle_cycle();

    // Reset while in WAIT; a later rvalid must be ignored.
    v = '{0, 1, 32'h040, 32'h0, 2'd2, 0, 32'h0, 0, 0, 4'b0, 32'h0, 32'h0, 0};
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; addr = v.a; len = v.ln; gnt = 1'b1; rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    gnt = 1'b0;
    #1;
    check("pre_rst_wait", {29'h0, dmem_req, stall, mem_done}, 32'b010);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; rd = 1'b0; rvalid = 1'b1; rdata = 32'hFFFFFFFF;
    #1;
    check("post_rst_flags", {29'h0, dmem_req, stall, mem_done}, 32'b000);
    check("post_rst_load", load_data_out, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    check("late_rvalid_done", 32'(mem_done), 32'h0);
    check("late_rvalid_load", load_data_out, 32'h0);
    last_load = 32'h0;
    @(posedge clk);

`ifdef MEM_MISALIGN_CHECK_EN
    // Seed load_data_out, then a misaligned word load must not touch it.
    v = '{0, 1, 32'h100, 32'h0, 2'd2, 0, 32'h5A5A0001, 0, 0, 4'b0, 32'h0, 32'h5A5A0001, 2};
    run_access(v);
    v = '{0, 1, 32'h102, 32'h0, 2'd2, 0, 32'h0, 0, 0, 4'b0, 32'h0, 32'h0, 1};
    run_access(v);
    idle_cycle();
`endif

    // Random accesses checked against the model.
    for (int n = 0; n < 60; n++) begin
      int off;
      v.a    = {20'h0, 12'($urandom)};
      v.w    = $urandom;
      v.ln   = 2'($urandom_range(0, 3));
      v.sgn  = 1'($urandom_range(0, 1));
      v.rdat = $urandom;
      v.gd   = $urandom_range(0, 3);
      v.rd_dly = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0:       begin v.st = 1; v.ld = 0; end
        1:       begin v.st = 0; v.ld = 1; end
        default: begin v.st = 1; v.ld = 1; end
      endcase
      off         = int'(v.a % 4);
      v.exp_strb  = m_strb(off, v.ln);
      v.exp_wdata = m_wdata(v.w, v.ln);
      v.exp_load  = m_load(v.rdat, off, v.ln, v.sgn);
      if (m_mis(v)) v.exp_stall = 1;
      else v.exp_stall = v.gd + 1 + ((v.ld && !v.st) ? v.rd_dly + 1 : 0);
      run_access(v);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
